// File: rtl/recv_stream_merge.sv
// Round-robin merge of Channel 64-bit receive streams into one packetised output stream.
// A hold register feeds the output register; packets close on length, idle timeout or flush.
module recv_stream_merge #(
    parameter int unsigned Channel = 4,
    parameter int unsigned MAX_PKT = 256,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                      m_axis_aclk,
    input  logic                      m_axis_areset,
    input  logic [Channel*64-1:0]     s_axis_tdata,
    input  logic [Channel-1:0]        s_axis_tvalid,
    output logic [Channel-1:0]        s_axis_tready,
    input  logic                      flush,
    output logic [63:0]               m_axis_tdata,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_tready
);

    localparam int unsigned PTR_W = (Channel > 1) ? $clog2(Channel) : 1;

    logic [63:0]      out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [63:0]      hold_data_q, hold_data_d;
    logic             hold_valid_q, hold_valid_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [15:0]      beat_cnt_q, beat_cnt_d;
    logic [15:0]      idle_cnt_q, idle_cnt_d;
    logic             flush_pend_q, flush_pend_d;

    logic [PTR_W-1:0] grant;
    logic             any_valid;
    logic [63:0]      grant_data;
    logic             out_free;
    logic             accept;
    logic             flush_act;
    logic             force_last;
    logic             move;

    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        for (int unsigned i = 0; i < Channel; i++) begin
            if (!any_valid && s_axis_tvalid[(32'(rr_ptr_q) + i) % Channel]) begin
                any_valid = 1'b1;
                grant     = PTR_W'((32'(rr_ptr_q) + i) % Channel);
            end
        end
        grant_data = s_axis_tdata[32'(grant)*64 +: 64];
    end

    // A flush pulse counts immediately so a word leaving in the same cycle carries tlast.
    assign flush_act  = flush_pend_q || (flush && hold_valid_q);
    assign out_free   = !out_valid_q || m_axis_tready;
    assign accept     = any_valid && (!hold_valid_q || out_free);
    assign force_last = (beat_cnt_q == 16'(MAX_PKT - 1)) ||
                        (idle_cnt_q == 16'(TIMEOUT - 1)) || flush_act;
    assign move       = hold_valid_q && out_free && (accept || force_last);

    always_comb begin
        s_axis_tready = '0;
        if (accept && !m_axis_areset) begin
            s_axis_tready[grant] = 1'b1;
        end
    end

    always_comb begin
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        rr_ptr_d     = rr_ptr_q;
        beat_cnt_d   = beat_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        flush_pend_d = flush_pend_q;

        if (move) begin
            out_data_d  = hold_data_q;
            out_valid_d = 1'b1;
            out_last_d  = force_last;
            beat_cnt_d  = force_last ? '0 : beat_cnt_q + 16'd1;
        end else if (out_free) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            hold_data_d  = grant_data;
            hold_valid_d = 1'b1;
            rr_ptr_d     = PTR_W'((32'(grant) + 1) % Channel);
        end else if (move) begin
            hold_valid_d = 1'b0;
        end

        if (accept || move || !hold_valid_q) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != 16'(TIMEOUT - 1)) begin
            idle_cnt_d = idle_cnt_q + 16'd1;
        end

        if (move) begin
            flush_pend_d = 1'b0;
        end else if (flush && hold_valid_q) begin
            flush_pend_d = 1'b1;
        end
    end

    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_areset) begin
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
            rr_ptr_q     <= '0;
            beat_cnt_q   <= '0;
            idle_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            rr_ptr_q     <= rr_ptr_d;
            beat_cnt_q   <= beat_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign m_axis_tdata  = out_data_q;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tlast  = out_last_q;

endmodule

// File: tb/tb_recv_stream_merge.sv
// Self-checking bench for recv_stream_merge (Channel=4, MAX_PKT=4, TIMEOUT=8):
// arbiter vector table plus hand-timed packet, back-pressure, flush and reset sequences.
module tb_recv_stream_merge;

    localparam int unsigned CH = 4;

    logic            m_axis_aclk = 1'b0;
    logic            m_axis_areset;
    logic [CH*64-1:0] s_axis_tdata;
    logic [CH-1:0]   s_axis_tvalid;
    logic [CH-1:0]   s_axis_tready;
    logic            flush;
    logic [63:0]     m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tlast;
    logic            m_axis_tready;

    always #5 m_axis_aclk = ~m_axis_aclk;

    recv_stream_merge #(
        .Channel(CH),
        .MAX_PKT(4),
        .TIMEOUT(8)
    ) dut (
        .m_axis_aclk  (m_axis_aclk),
        .m_axis_areset(m_axis_areset),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .flush        (flush),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready)
    );

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } exp_t;

    typedef struct packed {
        logic [3:0] tvalid;
        logic [3:0] tready;
        logic       last;
    } vec_t;

    exp_t sbq[$];
    exp_t mon_e;
    vec_t tbl[12];
    int   checks = 0;
    int   passes = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endfunction

    task automatic tick();
        @(posedge m_axis_aclk);
        #1;
    endtask

    task automatic set_ch(int c, logic [63:0] d);
        s_axis_tdata[c*64 +: 64] = d;
    endtask

    task automatic push(logic [63:0] d, logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        sbq.push_back(e);
    endtask

    task automatic drain(string nm, int budget);
        for (int i = 0; i < budget && sbq.size() != 0; i++) tick();
        chk({nm, "_drain"}, 64'(sbq.size()), 64'd0);
        repeat (2) tick();
    endtask

    task automatic do_reset();
        m_axis_areset = 1'b1;
        flush         = 1'b0;
        m_axis_tready = 1'b1;
        s_axis_tvalid = '1;
        tick();
        tick();
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_tdata", m_axis_tdata, 64'd0);
        chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
        sbq.delete();
        m_axis_areset = 1'b0;
        s_axis_tvalid = '0;
        tick();
    endtask

    // Output-side scoreboard: every accepted output beat must match the next expected word.
    always @(negedge m_axis_aclk) begin
        if (!m_axis_areset && m_axis_tvalid && m_axis_tready) begin
            if (sbq.size() == 0) begin
                checks++;
                $display("FAIL unexpected_beat: got data 0x%0h last %0b, expected no beat",
                         m_axis_tdata, m_axis_tlast);
            end else begin
                mon_e = sbq.pop_front();
                chk("out_data", m_axis_tdata, mon_e.data);
                chk("out_last", 64'(m_axis_tlast), 64'(mon_e.last));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{4'b1111, 4'b0001, 1'b0};
        tbl[1]  = '{4'b1111, 4'b0010, 1'b0};
        tbl[2]  = '{4'b0001, 4'b0001, 1'b0};
        tbl[3]  = '{4'b1001, 4'b1000, 1'b1};
        tbl[4]  = '{4'b0000, 4'b0000, 1'b0};
        tbl[5]  = '{4'b0110, 4'b0010, 1'b0};
        tbl[6]  = '{4'b0110, 4'b0100, 1'b0};
        tbl[7]  = '{4'b0011, 4'b0001, 1'b0};
        tbl[8]  = '{4'b1100, 4'b0100, 1'b1};
        tbl[9]  = '{4'b1111, 4'b1000, 1'b0};
        tbl[10] = '{4'b1010, 4'b0010, 1'b1};
        tbl[11] = '{4'b0000, 4'b0000, 1'b0};

        s_axis_tdata = '0;
        do_reset();

        // Arbiter vector table
        for (int v = 0; v < 12; v++) begin
            s_axis_tvalid = tbl[v].tvalid;
            for (int c = 0; c < 4; c++) set_ch(c, 64'(v * 16 + c));
            #1;
            chk($sformatf("tbl%0d_tready", v), 64'(s_axis_tready), 64'(tbl[v].tready));
            for (int c = 0; c < 4; c++)
                if (tbl[v].tready[c]) push(64'(v * 16 + c), tbl[v].last);
            tick();
        end
        s_axis_tvalid = '0;
        drain("table", 40);

        // Single isolated word: appears exactly in cycle TIMEOUT+1
        do_reset();
        s_axis_tvalid = 4'b0100;
        set_ch(2, 64'hA5);
        #1;
        chk("single_s_tready", 64'(s_axis_tready), 64'b0100);
        push(64'hA5, 1'b1);
        tick();
        s_axis_tvalid = '0;
        for (int k = 1; k <= 12; k++) begin
            chk($sformatf("single_tvalid_c%0d", k), 64'(m_axis_tvalid), 64'(k == 9));
            tick();
        end
        drain("single", 10);

        // All channels continuously valid
        do_reset();
        for (int c = 0; c < 4; c++) set_ch(c, 64'(c));
        for (int k = 0; k < 16; k++) begin
            s_axis_tvalid = 4'b1111;
            #1;
            chk($sformatf("rr_tready_%0d", k), 64'(s_axis_tready), 64'(1 << (k % 4)));
            push(64'(k % 4), (k % 4) == 3);
            tick();
        end
        s_axis_tvalid = '0;
        drain("rr", 20);

        // Back-pressure for 10 cycles; idle timeout closes the held word's packet
        do_reset();
        for (int c = 0; c < 4; c++) set_ch(c, 64'(256 + c));
        begin
            logic lasts [10];
            lasts = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
            for (int w = 0; w < 10; w++) push(64'(256 + (w % 4)), lasts[w]);
        end
        for (int k = 0; k < 20; k++) begin
            s_axis_tvalid = 4'b1111;
            m_axis_tready = !(k >= 6 && k <= 15);
            #1;
            if (k >= 6 && k <= 15) begin
                chk($sformatf("bp_tdata_%0d", k), m_axis_tdata, 64'd256);
                chk($sformatf("bp_tvalid_%0d", k), 64'(m_axis_tvalid), 64'd1);
                chk($sformatf("bp_tlast_%0d", k), 64'(m_axis_tlast), 64'd0);
                chk($sformatf("bp_s_tready_%0d", k), 64'(s_axis_tready), 64'd0);
            end
            tick();
        end
        s_axis_tvalid = '0;
        m_axis_tready = 1'b1;
        drain("bp", 20);

        // Flush while second word held; then flush with empty hold must not be stored
        do_reset();
        s_axis_tvalid = 4'b0010;
        set_ch(1, 64'h11); push(64'h11, 1'b0); tick();
        set_ch(1, 64'h12); push(64'h12, 1'b1); tick();
        s_axis_tvalid = '0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("flush_tdata", m_axis_tdata, 64'h12);
        chk("flush_tlast", 64'(m_axis_tlast), 64'd1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        s_axis_tvalid = 4'b0010;
        for (int w = 0; w < 4; w++) begin
            set_ch(1, 64'(8'h13 + w));
            push(64'(8'h13 + w), w == 3);
            tick();
        end
        s_axis_tvalid = '0;
        drain("flush", 20);

        // Flush coincident with accept of a new ch3 word
        do_reset();
        s_axis_tvalid = 4'b1000;
        set_ch(3, 64'h31); push(64'h31, 1'b1); tick();
        set_ch(3, 64'h32); push(64'h32, 1'b0); flush = 1'b1; tick();
        flush = 1'b0;
        set_ch(3, 64'h33); push(64'h33, 1'b0); tick();
        set_ch(3, 64'h34); push(64'h34, 1'b0); tick();
        set_ch(3, 64'h35); push(64'h35, 1'b1); tick();
        s_axis_tvalid = '0;
        drain("flush_acc", 20);

        // Reset with hold and output both valid
        do_reset();
        m_axis_tready = 1'b0;
        s_axis_tvalid = 4'b0010;
        set_ch(1, 64'h51); tick();
        set_ch(1, 64'h52); tick();
        chk("mid_tvalid_before", 64'(m_axis_tvalid), 64'd1);
        chk("mid_s_tready_full", 64'(s_axis_tready), 64'd0);
        m_axis_areset = 1'b1;
        s_axis_tvalid = 4'b1001;
        set_ch(0, 64'h60);
        set_ch(3, 64'h63);
        #1;
        chk("mid_s_tready_rst", 64'(s_axis_tready), 64'd0);
        tick();
        chk("mid_tvalid_after", 64'(m_axis_tvalid), 64'd0);
        m_axis_areset = 1'b0;
        m_axis_tready = 1'b1;
        #1;
        chk("mid_grant_ch0", 64'(s_axis_tready), 64'b0001);
        push(64'h60, 1'b0);
        tick();
        s_axis_tvalid = 4'b1000;
        #1;
        chk("mid_grant_ch3", 64'(s_axis_tready), 64'b1000);
        push(64'h63, 1'b1);
        tick();
        s_axis_tvalid = '0;
        drain("mid_rst", 20);

        chk("final_queue_empty", 64'(sbq.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
